demux_dois_fila: RTL and testbench

- 1-to-2 demultiplexer with a handshake: the write-side counterpart of the 2:1 selection mux in the 8-bit datapath.
- Takes one input word stream and routes each accepted word to destination 1 or 2 according to `selecao`.
- Each destination has its own 2-entry FIFO, so a stalled consumer does not lose data.
- Each destination has a per-destination count of accepted words.
- Sits between the ALU/result bus and two consumers (register-bank write port, memory write port).

---
 rtl/demux_dois_fila.sv | 95 +++++++++
 tb/tb_demux_dois_fila.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_dois_fila.sv
// 1-to-2 demultiplexer with a valid/ready handshake.
// Each destination has its own small FIFO and a counter of the words it has accepted.
module demux_dois_fila #(
    parameter int LARGURA = 8,
    parameter int PROF    = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               selecao,
    input  logic [LARGURA-1:0] entrada,
    input  logic               valido_entrada,
    output logic               pronto_entrada,
    output logic [LARGURA-1:0] saida1,
    output logic               valido1,
    input  logic               pronto1,
    output logic [LARGURA-1:0] saida2,
    output logic               valido2,
    input  logic               pronto2,
    output logic [7:0]         contagem1,
    output logic [7:0]         contagem2
);

    localparam int PW = $clog2(PROF);
    localparam logic [PW:0]   CHEIO      = (PW+1)'(PROF);
    localparam logic [PW:0]   PASSO_OCUP = (PW+1)'(1);
    localparam logic [PW-1:0] PASSO_PTR  = PW'(1);

    logic [1:0]               pronto_dst;
    logic [1:0]               valido_dst;
    logic [1:0]               push;
    logic [1:0]               pop;
    logic [1:0][PW:0]         ocup;
    logic [1:0][LARGURA-1:0]  cabeca;
    logic [1:0][7:0]          contagem;

    assign pronto_dst = {pronto2, pronto1};

    // A full FIFO still accepts when its head leaves on the same edge.
    assign pronto_entrada = !reset &&
                            ((ocup[selecao] < CHEIO) ||
                             (valido_dst[selecao] && pronto_dst[selecao]));

    assign push = {selecao, !selecao} & {2{valido_entrada && pronto_entrada}};
    assign pop  = valido_dst & pronto_dst;

    for (genvar g = 0; g < 2; g++) begin : g_fila
        logic [LARGURA-1:0] mem [PROF];
        logic [PW-1:0]      ptr_esc;
        logic [PW-1:0]      ptr_lei;
        logic [PW:0]        ocup_q;
        logic [7:0]         cont_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                ptr_esc <= '0;
                ptr_lei <= '0;
                ocup_q  <= '0;
                cont_q  <= '0;
            end else begin
                if (push[g]) begin
                    ptr_esc <= ptr_esc + PASSO_PTR;
                    cont_q  <= cont_q + 8'd1;
                end
                if (pop[g]) begin
                    ptr_lei <= ptr_lei + PASSO_PTR;
                end
                case ({push[g], pop[g]})
                    2'b10:   ocup_q <= ocup_q + PASSO_OCUP;
                    2'b01:   ocup_q <= ocup_q - PASSO_OCUP;
                    default: ocup_q <= ocup_q;
                endcase
            end
        end

        // When full, ptr_esc equals ptr_lei: the old head is presented before the edge that overwrites it.
        always_ff @(posedge clock) begin
            if (!reset && push[g]) begin
                mem[ptr_esc] <= entrada;
            end
        end

        assign ocup[g]       = ocup_q;
        assign valido_dst[g] = !reset && (ocup_q != '0);
        assign cabeca[g]     = valido_dst[g] ? mem[ptr_lei] : '0;
        assign contagem[g]   = cont_q;
    end

    assign saida1    = cabeca[0];
    assign saida2    = cabeca[1];
    assign valido1   = valido_dst[0];
    assign valido2   = valido_dst[1];
    assign contagem1 = contagem[0];
    assign contagem2 = contagem[1];

endmodule

// File: tb/tb_demux_dois_fila.sv
// Directed and random bench for demux_dois_fila; inputs are driven 1 time unit after each rising edge.
module tb_demux_dois_fila;

    logic       clock;
    logic       reset;
    logic       selecao;
    logic [7:0] entrada;
    logic       valido_entrada;
    logic       pronto_entrada;
    logic [7:0] saida1;
    logic       valido1;
    logic       pronto1;
    logic [7:0] saida2;
    logic       valido2;
    logic       pronto2;
    logic [7:0] contagem1;
    logic [7:0] contagem2;

    int vetores = 0;
    int erros   = 0;

    demux_dois_fila #(.LARGURA(8), .PROF(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .selecao        (selecao),
        .entrada        (entrada),
        .valido_entrada (valido_entrada),
        .pronto_entrada (pronto_entrada),
        .saida1         (saida1),
        .valido1        (valido1),
        .pronto1        (pronto1),
        .saida2         (saida2),
        .valido2        (valido2),
        .pronto2        (pronto2),
        .contagem1      (contagem1),
        .contagem2      (contagem2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Producer rule: a stalled word and its select must be held until accepted.
    logic       ant_hold = 1'b0;
    logic [7:0] ant_e    = 8'h00;
    logic       ant_s    = 1'b0;
    always @(negedge clock) begin
        if (ant_hold && valido_entrada && (entrada !== ant_e || selecao !== ant_s)) begin
            erros++;
            $display("FAIL regra_produtor entrada %h/%b changed from held %h/%b", entrada, selecao, ant_e, ant_s);
        end
        ant_hold <= valido_entrada && !pronto_entrada && !reset;
        ant_e    <= entrada;
        ant_s    <= selecao;
    end

    task automatic borda();
        @(posedge clock);
        #1;
    endtask

    task automatic aplica_reset();
        reset = 1'b1; valido_entrada = 1'b0; pronto1 = 1'b0; pronto2 = 1'b0;
        selecao = 1'b0; entrada = 8'h00;
        borda();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; valido_entrada = 1'b1; selecao = 1'b0; entrada = 8'h77;
        pronto1 = 1'b1; pronto2 = 1'b1;
        borda();
        borda();
        vetores++; if (pronto_entrada !== 1'b0) begin erros++; $display("FAIL reset_pronto_entrada got %b exp 0", pronto_entrada); end
        vetores++; if (valido1 !== 1'b0) begin erros++; $display("FAIL reset_valido1 got %b exp 0", valido1); end
        vetores++; if (valido2 !== 1'b0) begin erros++; $display("FAIL reset_valido2 got %b exp 0", valido2); end
        vetores++; if (saida1 !== 8'h00) begin erros++; $display("FAIL reset_saida1 got %h exp 00", saida1); end
        vetores++; if (contagem1 !== 8'h00) begin erros++; $display("FAIL reset_contagem1 got %h exp 00", contagem1); end
        vetores++; if (contagem2 !== 8'h00) begin erros++; $display("FAIL reset_contagem2 got %h exp 00", contagem2); end
        reset = 1'b0; valido_entrada = 1'b0;
        #1;
        vetores++; if (pronto_entrada !== 1'b1) begin erros++; $display("FAIL reset_pronto_apos got %b exp 1", pronto_entrada); end
        borda();
        vetores++; if (valido1 !== 1'b0) begin erros++; $display("FAIL pronto_sem_valido got %b exp 0", valido1); end
        vetores++; if (contagem1 !== 8'h00) begin erros++; $display("FAIL pronto_sem_valido_cont got %h exp 00", contagem1); end
    endtask

    task automatic test_basico();
        aplica_reset();
        pronto1 = 1'b1; pronto2 = 1'b1;
        selecao = 1'b0; entrada = 8'h01; valido_entrada = 1'b1;
        #1;
        vetores++; if (pronto_entrada !== 1'b1) begin erros++; $display("FAIL basico_pronto got %b exp 1", pronto_entrada); end
        borda();
        vetores++; if (valido1 !== 1'b1) begin erros++; $display("FAIL basico_valido1 got %b exp 1", valido1); end
        vetores++; if (saida1 !== 8'h01) begin erros++; $display("FAIL basico_saida1 got %h exp 01", saida1); end
        vetores++; if (contagem1 !== 8'h01) begin erros++; $display("FAIL basico_contagem1 got %h exp 01", contagem1); end
        vetores++; if (valido2 !== 1'b0) begin erros++; $display("FAIL basico_valido2_vazio got %b exp 0", valido2); end
        selecao = 1'b1; entrada = 8'h02;
        borda();
        vetores++; if (valido2 !== 1'b1) begin erros++; $display("FAIL basico_valido2 got %b exp 1", valido2); end
        vetores++; if (saida2 !== 8'h02) begin erros++; $display("FAIL basico_saida2 got %h exp 02", saida2); end
        vetores++; if (contagem2 !== 8'h01) begin erros++; $display("FAIL basico_contagem2 got %h exp 01", contagem2); end
        vetores++; if (valido1 !== 1'b0) begin erros++; $display("FAIL basico_valido1_pop got %b exp 0", valido1); end
        vetores++; if (contagem1 !== 8'h01) begin erros++; $display("FAIL basico_contagem1_pop got %h exp 01", contagem1); end
        valido_entrada = 1'b0;
        borda();
        vetores++; if (valido2 !== 1'b0) begin erros++; $display("FAIL basico_valido2_pop got %b exp 0", valido2); end
        vetores++; if (saida2 !== 8'h00) begin erros++; $display("FAIL basico_saida2_zero got %h exp 00", saida2); end
    endtask

    task automatic test_contrapressao();
        aplica_reset();
        selecao = 1'b0; valido_entrada = 1'b1; entrada = 8'hA1;
        borda();
        entrada = 8'hA2;
        borda();
        entrada = 8'hA3;
        #1;
        vetores++; if (pronto_entrada !== 1'b0) begin erros++; $display("FAIL cheio_pronto got %b exp 0", pronto_entrada); end
        vetores++; if (saida1 !== 8'hA1) begin erros++; $display("FAIL cheio_cabeca got %h exp a1", saida1); end
        borda();
        vetores++; if (saida1 !== 8'hA1) begin erros++; $display("FAIL cheio_cabeca_mantida got %h exp a1", saida1); end
        vetores++; if (contagem1 !== 8'h02) begin erros++; $display("FAIL cheio_contagem1 got %h exp 02", contagem1); end
        pronto1 = 1'b1;
        #1;
        vetores++; if (pronto_entrada !== 1'b1) begin erros++; $display("FAIL cheio_pop_push_pronto got %b exp 1", pronto_entrada); end
        borda();
        valido_entrada = 1'b0;
        vetores++; if (saida1 !== 8'hA2) begin erros++; $display("FAIL ordem_a2 got %h exp a2", saida1); end
        vetores++; if (contagem1 !== 8'h03) begin erros++; $display("FAIL cheio_contagem1_a3 got %h exp 03", contagem1); end
        borda();
        vetores++; if (saida1 !== 8'hA3) begin erros++; $display("FAIL ordem_a3 got %h exp a3", saida1); end
        vetores++; if (valido1 !== 1'b1) begin erros++; $display("FAIL ordem_a3_valido got %b exp 1", valido1); end
        borda();
        vetores++; if (valido1 !== 1'b0) begin erros++; $display("FAIL ordem_vazio got %b exp 0", valido1); end
    endtask

    task automatic test_independencia();
        aplica_reset();
        selecao = 1'b0; valido_entrada = 1'b1; entrada = 8'hB1;
        borda();
        entrada = 8'hB2;
        borda();
        selecao = 1'b1; entrada = 8'h55;
        #1;
        vetores++; if (pronto_entrada !== 1'b1) begin erros++; $display("FAIL indep_pronto got %b exp 1", pronto_entrada); end
        borda();
        selecao = 1'b0; entrada = 8'hB3;
        #1;
        vetores++; if (valido2 !== 1'b1) begin erros++; $display("FAIL indep_valido2 got %b exp 1", valido2); end
        vetores++; if (saida2 !== 8'h55) begin erros++; $display("FAIL indep_saida2 got %h exp 55", saida2); end
        vetores++; if (contagem2 !== 8'h01) begin erros++; $display("FAIL indep_contagem2 got %h exp 01", contagem2); end
        vetores++; if (saida1 !== 8'hB1) begin erros++; $display("FAIL indep_saida1 got %h exp b1", saida1); end
        vetores++; if (pronto_entrada !== 1'b0) begin erros++; $display("FAIL indep_pronto_d1 got %b exp 0", pronto_entrada); end
        valido_entrada = 1'b0; pronto2 = 1'b1;
        borda();
        vetores++; if (valido2 !== 1'b0) begin erros++; $display("FAIL indep_pop2 got %b exp 0", valido2); end
        vetores++; if (saida1 !== 8'hB1) begin erros++; $display("FAIL indep_saida1_fixa got %h exp b1", saida1); end
        vetores++; if (contagem1 !== 8'h02) begin erros++; $display("FAIL indep_contagem1 got %h exp 02", contagem1); end
    endtask

    task automatic test_volta_contador();
        aplica_reset();
        pronto2 = 1'b1; selecao = 1'b1; valido_entrada = 1'b1;
        for (int i = 0; i < 256; i++) begin
            entrada = 8'(i);
            #1;
            vetores++; if (pronto_entrada !== 1'b1) begin erros++; $display("FAIL volta_pronto[%0d] got %b exp 1", i, pronto_entrada); end
            borda();
            vetores++; if (saida2 !== 8'(i)) begin erros++; $display("FAIL volta_saida2[%0d] got %h exp %h", i, saida2, 8'(i)); end
            vetores++; if (contagem2 !== 8'(i + 1)) begin erros++; $display("FAIL volta_contagem2[%0d] got %h exp %h", i, contagem2, 8'(i + 1)); end
            vetores++; if (contagem1 !== 8'h00) begin erros++; $display("FAIL volta_contagem1[%0d] got %h exp 00", i, contagem1); end
        end
        valido_entrada = 1'b0;
        borda();
        vetores++; if (valido2 !== 1'b0) begin erros++; $display("FAIL volta_vazio got %b exp 0", valido2); end
    endtask

    task automatic test_reset_meio();
        aplica_reset();
        valido_entrada = 1'b1;
        selecao = 1'b0; entrada = 8'hC1; borda();
        entrada = 8'hC2; borda();
        selecao = 1'b1; entrada = 8'hD1; borda();
        entrada = 8'hD2; borda();
        vetores++; if (contagem1 !== 8'h02 || contagem2 !== 8'h02) begin erros++; $display("FAIL meio_contagens got %h/%h exp 02/02", contagem1, contagem2); end
        vetores++; if (saida2 !== 8'hD1) begin erros++; $display("FAIL meio_saida2 got %h exp d1", saida2); end
        selecao = 1'b0; entrada = 8'hEE; reset = 1'b1;
        #1;
        vetores++; if (pronto_entrada !== 1'b0) begin erros++; $display("FAIL meio_pronto got %b exp 0", pronto_entrada); end
        vetores++; if (valido1 !== 1'b0) begin erros++; $display("FAIL meio_valido1_reset got %b exp 0", valido1); end
        borda();
        reset = 1'b0; valido_entrada = 1'b0; pronto1 = 1'b1;
        #1;
        vetores++; if (valido1 !== 1'b0) begin erros++; $display("FAIL meio_valido1 got %b exp 0", valido1); end
        vetores++; if (valido2 !== 1'b0) begin erros++; $display("FAIL meio_valido2 got %b exp 0", valido2); end
        vetores++; if (contagem1 !== 8'h00) begin erros++; $display("FAIL meio_contagem1 got %h exp 00", contagem1); end
        vetores++; if (contagem2 !== 8'h00) begin erros++; $display("FAIL meio_contagem2 got %h exp 00", contagem2); end
        borda();
        vetores++; if (valido1 !== 1'b0) begin erros++; $display("FAIL meio_nao_armazenou got %b exp 0", valido1); end
    endtask

    task automatic test_aleatorio();
        logic [7:0] q1[$];
        logic [7:0] q2[$];
        int         c1 = 0;
        int         c2 = 0;
        bit         hold = 1'b0;
        logic       ev1, ev2, ep, acc;
        logic [7:0] es1, es2;
        aplica_reset();
        for (int ciclo = 0; ciclo < 2000; ciclo++) begin
            if (!hold) begin
                valido_entrada = ($urandom_range(0, 9) < 6);
                selecao        = 1'($urandom_range(0, 1));
                entrada        = 8'($urandom_range(0, 255));
            end
            pronto1 = 1'($urandom_range(0, 1));
            pronto2 = 1'($urandom_range(0, 1));
            #1;
            ev1 = (q1.size() != 0);
            ev2 = (q2.size() != 0);
            es1 = ev1 ? q1[0] : 8'h00;
            es2 = ev2 ? q2[0] : 8'h00;
            ep  = selecao ? ((q2.size() < 2) || (ev2 && pronto2))
                          : ((q1.size() < 2) || (ev1 && pronto1));
            vetores++; if (valido1 !== ev1) begin erros++; $display("FAIL rnd_valido1[%0d] got %b exp %b", ciclo, valido1, ev1); end
            vetores++; if (saida1 !== es1) begin erros++; $display("FAIL rnd_saida1[%0d] got %h exp %h", ciclo, saida1, es1); end
            vetores++; if (valido2 !== ev2) begin erros++; $display("FAIL rnd_valido2[%0d] got %b exp %b", ciclo, valido2, ev2); end
            vetores++; if (saida2 !== es2) begin erros++; $display("FAIL rnd_saida2[%0d] got %h exp %h", ciclo, saida2, es2); end
            vetores++; if (pronto_entrada !== ep) begin erros++; $display("FAIL rnd_pronto[%0d] got %b exp %b", ciclo, pronto_entrada, ep); end
            acc = valido_entrada && ep;
            if (ev1 && pronto1) void'(q1.pop_front());
            if (ev2 && pronto2) void'(q2.pop_front());
            if (acc) begin
                if (selecao) begin q2.push_back(entrada); c2++; end
                else         begin q1.push_back(entrada); c1++; end
            end
            hold = valido_entrada && !acc;
            borda();
        end
        vetores++; if (contagem1 !== 8'(c1)) begin erros++; $display("FAIL rnd_contagem1 got %h exp %h", contagem1, 8'(c1)); end
        vetores++; if (contagem2 !== 8'(c2)) begin erros++; $display("FAIL rnd_contagem2 got %h exp %h", contagem2, 8'(c2)); end
        valido_entrada = 1'b0;
    endtask

    initial begin
        reset = 1'b1; selecao = 1'b0; entrada = 8'h00; valido_entrada = 1'b0;
        pronto1 = 1'b0; pronto2 = 1'b0;
        #1;
        test_reset();
        test_basico();
        test_contrapressao();
        test_independencia();
        test_volta_contador();
        test_reset_meio();
        test_aleatorio();
        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
